pic_writer: RTL and testbench
=============================

PIC_WRITER -- requirements
Module: pic_writer

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port Control_CS, input, 2, controller state (0 INITIAL, 1 PIC_DRAW, 2 CR_DRAW).
REQ-004 SHALL have port i_mode_start, input, 3, picture-size start code (0 none; 1..4 valid; 5..7 invalid).
REQ-005 SHALL have port wr_ready, input, 1, frame-buffer accepts the write this cycle.
REQ-006 SHALL have port wr_en, output, 1, write request to 64x64 frame buffer.
REQ-007 SHALL have port wr_addr, output, 12, pixel address = y*64 + x.
REQ-008 SHALL have port wr_data, output, 12, RGB444 pixel.
REQ-009 SHALL have port PIC_Write_Done, output, 1, one-cycle done pulse to controller.
REQ-010 SHALL have port busy, output, 1, high in any state except IDLE.

Function
REQ-011 SHALL implement states IDLE, CLEAR (only when the REQ-026 macro is defined), DRAW, DONE and HOLD.
REQ-012 IDLE SHALL start when Control_CS==1 and i_mode_start is 1..4; codes 0 and 5..7 SHALL keep IDLE.
REQ-013 On start, SHALL latch side = 4 << i_mode_start (8/16/32/64) and zero x, y.
REQ-014 First wr_en SHALL assert the cycle after the start sample.
REQ-015 A write SHALL be accepted only when wr_en && wr_ready.
REQ-016 While wr_ready is low, wr_en, wr_addr and wr_data SHALL hold their values.
REQ-017 In DRAW, each accepted write SHALL increment x; at x==side-1, x SHALL wrap to 0 and y SHALL increment.
REQ-018 DRAW pixel value SHALL be wr_data = {x[3:0], y[3:0], x[3:0]^y[3:0]} and wr_addr = {y[5:0], x[5:0]}.
REQ-019 Acceptance at x==side-1, y==side-1 SHALL move DRAW to DONE; exactly side*side writes SHALL be issued.
REQ-020 DONE SHALL assert PIC_Write_Done for exactly one cycle with wr_en low, then move to HOLD.
REQ-021 HOLD SHALL return to IDLE only once Control_CS != 1, so one PIC_DRAW phase never draws twice.
REQ-022 Abort: if Control_CS != 1 in CLEAR or DRAW, the block SHALL go to IDLE next cycle, deassert wr_en and not pulse PIC_Write_Done.
REQ-023 i_mode_start changes after start SHALL be ignored until IDLE is re-entered.

Reset
REQ-024 On reset, the state SHALL be IDLE, and wr_en, wr_addr, wr_data, PIC_Write_Done, busy, x, y and latched side SHALL all be 0.
REQ-025 Reset SHALL override every state, including mid-write with wr_ready low, and SHALL take effect at the next clock edge.

Configuration
REQ-026 Macro PIC_CLEAR_EN: when defined, start SHALL enter CLEAR instead of DRAW.
REQ-027 CLEAR SHALL write wr_data 0 to all 4096 addresses (0..4095, ascending, same handshake as REQ-015/016), then enter DRAW with x=y=0.
REQ-028 When PIC_CLEAR_EN is undefined, start SHALL enter DRAW directly, and no CLEAR state or logic SHALL exist.

Verification
REQ-029 Size 8 run: Control_CS=1, i_mode_start=1, wr_ready=1 -> 64 writes; the first is addr 0x000 data 0x000; the write at x=7,y=7 is addr 0x1C7 data 0x770; PIC_Write_Done pulses 1 cycle after the last write.
REQ-030 Backpressure: i_mode_start=2 with wr_ready toggled 0/1 each cycle -> exactly 256 accepted writes, outputs stable while not ready, addresses in raster order.
REQ-031 Abort: Control_CS goes 1 -> 2 after 10 accepted writes of a size-32 run -> wr_en low next cycle, busy low, PIC_Write_Done never asserted.
REQ-032 Invalid code: i_mode_start=6 held with Control_CS=1 for 20 cycles -> wr_en stays 0 and busy stays 0.
REQ-033 Hold: Control_CS stays 1 with i_mode_start=1 after done -> no second run; Control_CS goes to 2 then back to 1 -> new run starts.
REQ-034 PIC_CLEAR_EN defined, size 8 -> 4096 zero writes, then 64 pattern writes, then 1 done pulse; reset asserted mid-CLEAR -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pic_writer_if.sv
// rtl/pic_writer_if.sv - frame-buffer write bus between pic_writer and a 64x64 RGB444 buffer
// Signals:
//   wr_en    : write request, held until accepted
//   wr_addr  : 12-bit pixel address (y*64 + x)
//   wr_data  : 12-bit RGB444 pixel
//   wr_ready : buffer accepts the pending write on this cycle
// Modports: master (pixel source), slave (frame buffer).
interface pic_writer_if;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_ready;

    modport master (output wr_en, wr_addr, wr_data, input  wr_ready);
    modport slave  (input  wr_en, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/pic_writer.sv
// rtl/pic_writer.sv - draws a square test pattern into a 64x64 RGB444 frame buffer
// Ports:
//   clk            : single clock, rising edge
//   reset          : synchronous active-high reset
//   Control_CS     : controller state (0 INITIAL, 1 PIC_DRAW, 2 CR_DRAW)
//   i_mode_start   : picture-size code, 1..4 selects side 8/16/32/64
//   wr             : frame-buffer write bus (master side)
//   PIC_Write_Done : one-cycle pulse after the last pattern pixel is accepted
//   busy           : high whenever the writer is not idle
// Build option: PIC_CLEAR_EN - clear all 4096 pixels to 0 before drawing.
module pic_writer (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    Control_CS,
    input  logic [2:0]    i_mode_start,
    pic_writer_if.master  wr,
    output logic          PIC_Write_Done,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE,
`ifdef PIC_CLEAR_EN
        CLEAR,
`endif
        DRAW,
        DONE,
        HOLD
    } state_t;

    state_t     state;
    logic [6:0] side;
    logic [5:0] x;
    logic [5:0] y;

    logic       cs_draw;
    logic       start_ok;
    logic       x_last;
    logic       y_last;
    logic [5:0] nx;
    logic [5:0] ny;

    assign cs_draw  = (Control_CS == 2'd1);
    assign start_ok = cs_draw && (i_mode_start >= 3'd1) && (i_mode_start <= 3'd4);

    // Coordinates of the pixel that follows the one currently on the bus.
    assign x_last = ({1'b0, x} == side - 7'd1);
    assign y_last = ({1'b0, y} == side - 7'd1);
    assign nx     = x_last ? 6'd0 : x + 6'd1;
    assign ny     = x_last ? y + 6'd1 : y;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            side           <= 7'd0;
            x              <= 6'd0;
            y              <= 6'd0;
            wr.wr_en       <= 1'b0;
            wr.wr_addr     <= 12'd0;
            wr.wr_data     <= 12'd0;
            PIC_Write_Done <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    PIC_Write_Done <= 1'b0;
                    if (start_ok) begin
                        side       <= 7'd4 << i_mode_start;
                        x          <= 6'd0;
                        y          <= 6'd0;
                        wr.wr_en   <= 1'b1;
                        wr.wr_addr <= 12'd0;
                        wr.wr_data <= 12'd0;
                        busy       <= 1'b1;
`ifdef PIC_CLEAR_EN
                        state      <= CLEAR;
`else
                        state      <= DRAW;
`endif
                    end
                end
`ifdef PIC_CLEAR_EN
                CLEAR: begin
                    // wr_addr doubles as the clear counter; wr_data stays 0 throughout.
                    if (!cs_draw) begin
                        state    <= IDLE;
                        wr.wr_en <= 1'b0;
                        busy     <= 1'b0;
                    end else if (wr.wr_ready) begin
                        if (wr.wr_addr == 12'hFFF) begin
                            state      <= DRAW;
                            wr.wr_addr <= 12'd0;
                        end else begin
                            wr.wr_addr <= wr.wr_addr + 12'd1;
                        end
                    end
                end
`endif
                DRAW: begin
                    if (!cs_draw) begin
                        state    <= IDLE;
                        wr.wr_en <= 1'b0;
                        busy     <= 1'b0;
                    end else if (wr.wr_ready) begin
                        if (x_last && y_last) begin
                            state          <= DONE;
                            wr.wr_en       <= 1'b0;
                            PIC_Write_Done <= 1'b1;
                        end else begin
                            x          <= nx;
                            y          <= ny;
                            wr.wr_addr <= {ny, nx};
                            wr.wr_data <= {nx[3:0], ny[3:0], nx[3:0] ^ ny[3:0]};
                        end
                    end
                end
                DONE: begin
                    PIC_Write_Done <= 1'b0;
                    state          <= HOLD;
                end
                HOLD: begin
                    // Stay here for the rest of this PIC_DRAW phase so it draws only once.
                    if (!cs_draw) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    wr.wr_en       <= 1'b0;
                    PIC_Write_Done <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pic_writer.sv
// tb/tb_pic_writer.sv - self-checking bench for pic_writer
module tb_pic_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Control_CS;
    logic [2:0] i_mode_start;
    logic       PIC_Write_Done;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [11:0] obs_addr [0:8191];
    logic [11:0] obs_data [0:8191];

`ifdef PIC_CLEAR_EN
    localparam int CLR_WRITES = 4096;
`else
    localparam int CLR_WRITES = 0;
`endif

    pic_writer_if bus ();

    pic_writer dut (
        .clk            (clk),
        .reset          (reset),
        .Control_CS     (Control_CS),
        .i_mode_start   (i_mode_start),
        .wr             (bus.master),
        .PIC_Write_Done (PIC_Write_Done),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cs;
        logic [2:0] mode;
        logic       exp_en;
        logic       exp_busy;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference pixel from the picture rules: address y*64+x, colour built from low nibbles.
    function automatic int pixel_word(input int x, input int y);
        int addr;
        int data;
        addr = y * 64 + x;
        data = ((x % 16) << 8) | ((y % 16) << 4) | ((x % 16) ^ (y % 16));
        return addr * 4096 + data;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        Control_CS   = 2'd0;
        i_mode_start = 3'd0;
        bus.wr_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic leave_draw();
        Control_CS = 2'd2;
        @(negedge clk);
        chk("leave_busy", int'(busy), 0);
        chk("leave_wr_en", int'(bus.wr_en), 0);
    endtask

    // rpat: 0 always ready, 1 toggling ready, 2 random ready
    task automatic run_picture(input int code, input int rpat, input bit scramble);
        int   exp_q[$];
        int   side;
        int   total;
        int   n_acc;
        int   n_done;
        int   last_acc;
        int   done_cyc;
        int   budget;
        int   w;
        bit   prev_stall;
        bit   rdy;
        logic [11:0] pa;
        logic [11:0] pd;

        side = 4 << code;
        for (int a = 0; a < CLR_WRITES; a++) exp_q.push_back(a * 4096);
        for (int yy = 0; yy < side; yy++)
            for (int xx = 0; xx < side; xx++)
                exp_q.push_back(pixel_word(xx, yy));
        total      = exp_q.size();
        budget     = 4 * total + 50;
        n_acc      = 0;
        n_done     = 0;
        last_acc   = -10;
        done_cyc   = -10;
        prev_stall = 1'b0;
        pa         = 12'd0;
        pd         = 12'd0;

        @(negedge clk);
        Control_CS   = 2'd1;
        i_mode_start = 3'(code);

        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (scramble) i_mode_start = 3'($urandom_range(0, 7));
            if (cyc == 0) chk("first_wr_en", int'(bus.wr_en), 1);
            if (PIC_Write_Done) begin
                n_done++;
                done_cyc = cyc;
                chk("done_wr_en", int'(bus.wr_en), 0);
            end
            if (prev_stall) begin
                chk("stall_wr_en", int'(bus.wr_en), 1);
                chk("stall_addr", int'(bus.wr_addr), int'(pa));
                chk("stall_data", int'(bus.wr_data), int'(pd));
            end
            case (rpat)
                0:       rdy = 1'b1;
                1:       rdy = cyc[0];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (bus.wr_en && rdy) begin
                if (exp_q.size() == 0) begin
                    chk("extra_write", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    chk("wr_addr", int'(bus.wr_addr), w / 4096);
                    chk("wr_data", int'(bus.wr_data), w % 4096);
                end
                if (n_acc < 8192) begin
                    obs_addr[n_acc] = bus.wr_addr;
                    obs_data[n_acc] = bus.wr_data;
                end
                n_acc++;
                last_acc = cyc;
            end
            prev_stall   = bus.wr_en && !rdy;
            pa           = bus.wr_addr;
            pd           = bus.wr_data;
            bus.wr_ready = rdy;
            if (n_done > 0 && cyc >= done_cyc + 3) break;
        end

        chk("write_count", n_acc, total);
        chk("done_pulses", n_done, 1);
        chk("done_latency", done_cyc, last_acc + 1);
        chk("hold_busy", int'(busy), 1);
        chk("hold_wr_en", int'(bus.wr_en), 0);
    endtask

    vec_t vecs [11];

    initial begin
        int n_acc;
        int base;

        vecs[0]  = '{2'd1, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{2'd1, 3'd1, 1'b1, 1'b1};
        vecs[2]  = '{2'd1, 3'd2, 1'b1, 1'b1};
        vecs[3]  = '{2'd1, 3'd3, 1'b1, 1'b1};
        vecs[4]  = '{2'd1, 3'd4, 1'b1, 1'b1};
        vecs[5]  = '{2'd1, 3'd5, 1'b0, 1'b0};
        vecs[6]  = '{2'd1, 3'd6, 1'b0, 1'b0};
        vecs[7]  = '{2'd1, 3'd7, 1'b0, 1'b0};
        vecs[8]  = '{2'd0, 3'd2, 1'b0, 1'b0};
        vecs[9]  = '{2'd2, 3'd3, 1'b0, 1'b0};
        vecs[10] = '{2'd3, 3'd1, 1'b0, 1'b0};

        reset        = 1'b1;
        Control_CS   = 2'd0;
        i_mode_start = 3'd0;
        bus.wr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_wr_en", int'(bus.wr_en), 0);
        chk("rst_wr_addr", int'(bus.wr_addr), 0);
        chk("rst_wr_data", int'(bus.wr_data), 0);
        chk("rst_done", int'(PIC_Write_Done), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;

        // Start-condition table: one sample edge per entry.
        for (int i = 0; i < 11; i++) begin
            do_reset();
            Control_CS   = vecs[i].cs;
            i_mode_start = vecs[i].mode;
            @(negedge clk);
            chk($sformatf("vec%0d_wr_en", i), int'(bus.wr_en), int'(vecs[i].exp_en));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_addr", i), int'(bus.wr_addr), 0);
            chk($sformatf("vec%0d_done", i), int'(PIC_Write_Done), 0);
        end

        // Size 8, always ready, then hold and restart.
        do_reset();
        run_picture(1, 0, 1'b0);
        base = CLR_WRITES;
        chk("first_addr", int'(obs_addr[base]), 12'h000);
        chk("first_data", int'(obs_data[base]), 12'h000);
        chk("xy77_addr", int'(obs_addr[base + 63]), 12'h1C7);
        chk("xy77_data", int'(obs_data[base + 63]), 12'h770);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_no_rerun", int'(bus.wr_en), 0);
            chk("hold_busy_stays", int'(busy), 1);
        end
        leave_draw();
        run_picture(1, 0, 1'b0);
        leave_draw();

        // Size 16 with ready toggling every cycle.
        run_picture(2, 1, 1'b0);
        leave_draw();

        // Random sizes, random ready, i_mode_start disturbed mid-run.
        for (int r = 0; r < 2; r++) begin
            run_picture(int'($urandom_range(1, 4)), 2, 1'b1);
            leave_draw();
        end

        // Abort a size-32 run after 10 accepted writes.
        do_reset();
        Control_CS   = 2'd1;
        i_mode_start = 3'd3;
        bus.wr_ready = 1'b1;
        n_acc = 0;
        for (int cyc = 0; cyc < 50 && n_acc < 10; cyc++) begin
            @(negedge clk);
            if (bus.wr_en) n_acc++;
        end
        chk("abort_pre_count", n_acc, 10);
        @(negedge clk);
        Control_CS   = 2'd2;
        bus.wr_ready = 1'b0;
        @(negedge clk);
        chk("abort_wr_en", int'(bus.wr_en), 0);
        chk("abort_busy", int'(busy), 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("abort_no_done", int'(PIC_Write_Done), 0);
            chk("abort_idle_wr_en", int'(bus.wr_en), 0);
        end

        // Invalid start code held for 20 cycles.
        do_reset();
        Control_CS   = 2'd1;
        i_mode_start = 3'd6;
        bus.wr_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("inv_wr_en", int'(bus.wr_en), 0);
            chk("inv_busy", int'(busy), 0);
        end

        // Reset mid-write with wr_ready low.
        do_reset();
        Control_CS   = 2'd1;
        i_mode_start = 3'd2;
        bus.wr_ready = 1'b1;
        for (int i = 0; i < 6; i++) @(negedge clk);
        chk("pre_rst_wr_en", int'(bus.wr_en), 1);
        chk("pre_rst_addr_nz", int'(bus.wr_addr != 12'd0), 1);
        bus.wr_ready = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        chk("mid_rst_wr_en", int'(bus.wr_en), 0);
        chk("mid_rst_addr", int'(bus.wr_addr), 0);
        chk("mid_rst_data", int'(bus.wr_data), 0);
        chk("mid_rst_done", int'(PIC_Write_Done), 0);
        chk("mid_rst_busy", int'(busy), 0);
        reset = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
